// File: rtl/ara_pkg.sv
// ara_pkg -- shared types for the vector lane operand path.
//
// Holds the command descriptor that accompanies every operand read stream
// and the number of operand queues per lane. The operand requester builds
// one operand_requester_channel per operand queue.
package ara_pkg;

  // Number of operand queues per lane; one requester channel serves each.
  localparam int unsigned NrOperandQueues = 9;

  // Element width of the vector operand being streamed.
  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;

  // Command the operand queue needs to unpack the words it receives.
  typedef struct packed {
    vew_e        eew;      // element width of the operand
    logic [15:0] vl;       // vector length in elements
    logic [1:0]  conv;     // conversion applied while unpacking
    logic        ntr_red;  // operand feeds a non-trivial reduction
  } operand_queue_cmd_t;

endpackage : ara_pkg

// File: rtl/operand_requester_channel.sv
// operand_requester_channel -- one read-stream channel of the operand requester.
//
// Accepts a request for req_len_i consecutive 64-bit VRF words starting at
// req_addr_i, forwards the accompanying command to the operand queue as a
// one-cycle strobe, and then issues one VRF read per arbiter grant. Reads are
// throttled by a credit counter mirroring the free slots of the downstream
// operand queue, so the queue can never overflow.
//
// Ports:
//   clk_i, rst_i                  clock; synchronous active-high reset
//   req_valid_i / req_ready_o     stream request handshake (ready only in IDLE)
//   req_addr_i, req_len_i         first word address and word count
//   req_cmd_i                     command forwarded to the operand queue
//   operand_queue_cmd_o/_valid_o  latched command and its one-cycle strobe
//   vrf_req_o, vrf_addr_o         VRF read request and word address
//   vrf_bank_o                    bank of vrf_addr_o (address mod NrBanks)
//   vrf_gnt_i                     bank arbiter grant; read issues on grant
//   operand_issued_o              a read was granted this cycle
//   operand_queue_ready_i         the queue freed one slot (credit return)
module operand_requester_channel
  import ara_pkg::*;
#(
  parameter int unsigned NrBanks     = 8,
  parameter int unsigned BufferDepth = 2,
  parameter int unsigned AddrWidth   = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [AddrWidth-1:0]       req_addr_i,
  input  logic [15:0]                req_len_i,
  input  operand_queue_cmd_t         req_cmd_i,
  output operand_queue_cmd_t         operand_queue_cmd_o,
  output logic                       operand_queue_cmd_valid_o,
  output logic                       vrf_req_o,
  output logic [AddrWidth-1:0]       vrf_addr_o,
  output logic [$clog2(NrBanks)-1:0] vrf_bank_o,
  input  logic                       vrf_gnt_i,
  output logic                       operand_issued_o,
  input  logic                       operand_queue_ready_i
);

  localparam int unsigned BankWidth   = $clog2(NrBanks);
  localparam int unsigned CreditWidth = $clog2(BufferDepth + 1);
  localparam logic [CreditWidth-1:0] MaxCredits = CreditWidth'(BufferDepth);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [15:0]            remaining_q;
  logic [CreditWidth-1:0] credits_q;
  logic [CreditWidth-1:0] credits_d;
  operand_queue_cmd_t     cmd_q;
  logic                   cmd_valid_q;
  logic                   credit_ret_ok;

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registered state, no path from req_* inputs.
  // ---------------------------------------------------------------------------
  assign req_ready_o               = (state_q == IDLE);
  assign vrf_req_o                 = (state_q == ISSUE) && (credits_q != '0) &&
                                     (remaining_q != '0);
  assign vrf_addr_o                = addr_q;
  // NrBanks is a power of two, so the low address bits select the bank.
  assign vrf_bank_o                = addr_q[BankWidth-1:0];
  // A grant without a request is meaningless and must not count as a read.
  assign operand_issued_o          = vrf_req_o & vrf_gnt_i;
  assign operand_queue_cmd_o       = cmd_q;
  assign operand_queue_cmd_valid_o = cmd_valid_q;

  // ---------------------------------------------------------------------------
  // Credit accounting
  // ---------------------------------------------------------------------------
  // A return while the counter is full (and nothing is being consumed) would
  // overflow it; such a return is dropped so the counter saturates.
  assign credit_ret_ok = operand_queue_ready_i &&
                         !((credits_q == MaxCredits) && !operand_issued_o);

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    credits_d = credits_q;
    unique case ({credit_ret_ok, operand_issued_o})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: credits_d = credits_q;  // none, or a return cancelling a grant
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Resetting mid-stream abandons it; outstanding credits are forgotten
      // because the queue is reset alongside this channel.
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      credits_q   <= MaxCredits;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      credits_q   <= credits_d;

      unique case (state_q)
        IDLE: begin
          // A zero-length request is accepted but produces nothing.
          if (req_valid_i && (req_len_i != '0)) begin
            addr_q      <= req_addr_i;
            remaining_q <= req_len_i;
            cmd_q       <= req_cmd_i;
            cmd_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end

        ISSUE: begin
          if (operand_issued_o) begin
            addr_q      <= addr_q + 1'b1;  // wraps modulo 2^AddrWidth
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              state_q <= IDLE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // A credit the queue returns while the counter is already full means the
  // queue and this channel disagree about occupancy.
  credit_overflow_a : assert property (
    @(posedge clk_i) disable iff (rst_i)
      !(operand_queue_ready_i && (credits_q == MaxCredits) && !operand_issued_o)
  );

endmodule : operand_requester_channel
